// File: rtl/cv32e40p_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_pc_redirect_unit
// Brief    : Registered next-PC redirect selection with a single-entry
//            valid/ready buffer towards the prefetcher.
// Revision : 1.0
// ============================================================================
module cv32e40p_pc_redirect_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int VEC_WIDTH   = 5,
    parameter int NUM_TRAP_CH = 2,
    parameter int CH_W        = (NUM_TRAP_CH > 1) ? $clog2(NUM_TRAP_CH) : 1,
    localparam int TB_W       = ADDR_WIDTH - VEC_WIDTH - 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH-1:0]             boot_addr_i,
    input  logic [ADDR_WIDTH-1:0]             dm_halt_addr_i,
    input  logic [ADDR_WIDTH-1:0]             dm_exception_addr_i,
    input  logic [NUM_TRAP_CH*TB_W-1:0]       trap_base_addr_i,
    input  logic [NUM_TRAP_CH*VEC_WIDTH-1:0]  exc_vec_i,
    input  logic [NUM_TRAP_CH*ADDR_WIDTH-1:0] epc_i,
    input  logic [ADDR_WIDTH-1:0]             depc_i,
    input  logic [CH_W-1:0]                   trap_ch_i,
    input  logic [2:0]                        exc_pc_mux_i,
    input  logic                              pc_set_i,
    input  logic [3:0]                        pc_mux_i,
    input  logic [ADDR_WIDTH-1:0]             jump_target_id_i,
    input  logic [ADDR_WIDTH-1:0]             jump_target_ex_i,
    input  logic [ADDR_WIDTH-1:0]             pc_id_i,
    input  logic [ADDR_WIDTH-1:0]             hwlp_target_i,
    input  logic                              fetch_ready_i,
    output logic                              branch_valid_o,
    output logic [ADDR_WIDTH-1:0]             branch_addr_o,
    output logic                              csr_tvec_init_o,
    output logic                              redirect_drop_o
);

    localparam logic [3:0] c_pc_boot      = 4'b0000;
    localparam logic [3:0] c_pc_fencei    = 4'b0001;
    localparam logic [3:0] c_pc_jump      = 4'b0010;
    localparam logic [3:0] c_pc_branch    = 4'b0011;
    localparam logic [3:0] c_pc_exception = 4'b0100;
    localparam logic [3:0] c_pc_mret      = 4'b0101;
    localparam logic [3:0] c_pc_uret      = 4'b0110;
    localparam logic [3:0] c_pc_dret      = 4'b0111;
    localparam logic [3:0] c_pc_hwloop    = 4'b1000;

    localparam logic [2:0] c_exc_irq      = 3'b001;
    localparam logic [2:0] c_exc_dbd      = 3'b010;
    localparam logic [2:0] c_exc_dbe      = 3'b011;

    localparam logic [1:0] c_st_boot      = 2'd0;
    localparam logic [1:0] c_st_idle      = 2'd1;
    localparam logic [1:0] c_st_pend      = 2'd2;

    localparam logic [CH_W:0]         c_num_ch = NUM_TRAP_CH[CH_W:0];
    localparam logic [ADDR_WIDTH-1:0] c_pc_inc = ADDR_WIDTH'(4);

    logic [TB_W-1:0]       w_base [NUM_TRAP_CH];
    logic [VEC_WIDTH-1:0]  w_vec  [NUM_TRAP_CH];
    logic [ADDR_WIDTH-1:0] w_epc  [NUM_TRAP_CH];

    genvar g_c;
    generate
        for (g_c = 0; g_c < NUM_TRAP_CH; g_c++) begin : g_unpack
            assign w_base[g_c] = trap_base_addr_i[g_c*TB_W +: TB_W];
            assign w_vec[g_c]  = exc_vec_i[g_c*VEC_WIDTH +: VEC_WIDTH];
            assign w_epc[g_c]  = epc_i[g_c*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    logic [CH_W-1:0]       w_ch;
    logic [ADDR_WIDTH-1:0] w_boot_aligned;
    logic [ADDR_WIDTH-1:0] w_exc_pc;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_mux_ok;
    logic                  w_set_ok;
    logic                  w_unused_ok;

    // Out-of-range channel indices fall back to the machine channel
    assign w_ch           = ({1'b0, trap_ch_i} < c_num_ch) ? trap_ch_i : '0;
    assign w_boot_aligned = {boot_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_ok    = ^{boot_addr_i[1:0], dm_halt_addr_i[1:0], dm_exception_addr_i[1:0]};

    always_comb begin
        w_exc_pc = {w_base[w_ch], {(VEC_WIDTH+3){1'b0}}};
        case (exc_pc_mux_i)
            c_exc_irq: w_exc_pc = {w_base[w_ch], 1'b0, w_vec[w_ch], 2'b00};
            c_exc_dbd: w_exc_pc = {dm_halt_addr_i[ADDR_WIDTH-1:2], 2'b00};
            c_exc_dbe: w_exc_pc = {dm_exception_addr_i[ADDR_WIDTH-1:2], 2'b00};
            default:   w_exc_pc = {w_base[w_ch], {(VEC_WIDTH+3){1'b0}}};
        endcase
    end

    always_comb begin
        w_target = '0;
        w_mux_ok = 1'b1;
        case (pc_mux_i)
            c_pc_boot:      w_target = w_boot_aligned;
            c_pc_jump:      w_target = jump_target_id_i;
            c_pc_branch:    w_target = jump_target_ex_i;
            c_pc_exception: w_target = w_exc_pc;
            c_pc_mret:      w_target = w_epc[0];
            c_pc_uret:      w_target = w_epc[NUM_TRAP_CH-1];
            c_pc_dret:      w_target = depc_i;
            c_pc_fencei:    w_target = pc_id_i + c_pc_inc;
            c_pc_hwloop:    w_target = hwlp_target_i;
            default:        w_mux_ok = 1'b0;
        endcase
    end

    assign w_set_ok = pc_set_i & w_mux_ok;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_tvec_init;
    logic                  r_drop;
    logic                  w_load;
    logic                  w_tvec_nxt;
    logic                  w_drop_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_boot;
            r_addr      <= '0;
            r_tvec_init <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tvec_init <= w_tvec_nxt;
            r_drop      <= w_drop_nxt;
            if (w_load) begin
                r_addr <= w_target;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_boot: if (fetch_ready_i) w_state_nxt = c_st_idle;
            c_st_idle: if (w_set_ok)      w_state_nxt = c_st_pend;
            c_st_pend: begin
                if (w_set_ok)           w_state_nxt = c_st_pend;
                else if (fetch_ready_i) w_state_nxt = c_st_idle;
            end
            default:                    w_state_nxt = c_st_boot;
        endcase
    end

    // Newest redirect wins; the overwritten one is flagged only if it was never taken
    always_comb begin
        w_load     = w_set_ok & (r_state != c_st_boot);
        w_tvec_nxt = ((r_state == c_st_boot) & fetch_ready_i) |
                     (w_load & (pc_mux_i == c_pc_boot));
        w_drop_nxt = (r_state == c_st_pend) & w_set_ok & ~fetch_ready_i;
    end

    assign branch_valid_o  = (r_state == c_st_boot) | (r_state == c_st_pend);
    assign branch_addr_o   = (r_state == c_st_boot) ? w_boot_aligned : r_addr;
    assign csr_tvec_init_o = r_tvec_init;
    assign redirect_drop_o = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_pc_redirect_unit
// Brief    : Directed table-driven bench for the PC redirect unit.
// Revision : 1.0
// ============================================================================
module tb_cv32e40p_pc_redirect_unit;

    localparam logic [3:0] PC_BOOT = 4'h0, PC_FENCEI = 4'h1, PC_JUMP = 4'h2, PC_BRANCH = 4'h3;
    localparam logic [3:0] PC_EXC = 4'h4, PC_MRET = 4'h5, PC_URET = 4'h6, PC_DRET = 4'h7;
    localparam logic [3:0] PC_HWLP = 4'h8;
    localparam logic [2:0] E_EXC = 3'd0, E_IRQ = 3'd1, E_DBD = 3'd2, E_DBE = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] boot_addr, dm_halt, dm_exc, depc, jid, jex, pcid, hwlp;
    logic        trap_ch;
    logic [1:0]  trap_ch3;
    logic [2:0]  exc_mux;
    logic        pc_set, fetch_ready;
    logic [3:0]  pc_mux;
    logic        valid, tvec, drop, valid3, tvec3, drop3;
    logic [31:0] addr, addr3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cv32e40p_pc_redirect_unit u_dut (
        .clk(clk), .rst(rst),
        .boot_addr_i(boot_addr), .dm_halt_addr_i(dm_halt), .dm_exception_addr_i(dm_exc),
        .trap_base_addr_i({24'h00ABCD, 24'h123456}),
        .exc_vec_i({5'd7, 5'd3}),
        .epc_i({32'h2000_0000, 32'h1000_0000}),
        .depc_i(depc), .trap_ch_i(trap_ch), .exc_pc_mux_i(exc_mux),
        .pc_set_i(pc_set), .pc_mux_i(pc_mux),
        .jump_target_id_i(jid), .jump_target_ex_i(jex), .pc_id_i(pcid), .hwlp_target_i(hwlp),
        .fetch_ready_i(fetch_ready),
        .branch_valid_o(valid), .branch_addr_o(addr),
        .csr_tvec_init_o(tvec), .redirect_drop_o(drop)
    );

    cv32e40p_pc_redirect_unit #(.NUM_TRAP_CH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .boot_addr_i(boot_addr), .dm_halt_addr_i(dm_halt), .dm_exception_addr_i(dm_exc),
        .trap_base_addr_i({24'h777777, 24'h00ABCD, 24'h123456}),
        .exc_vec_i({5'd9, 5'd7, 5'd3}),
        .epc_i({32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .depc_i(depc), .trap_ch_i(trap_ch3), .exc_pc_mux_i(exc_mux),
        .pc_set_i(pc_set), .pc_mux_i(pc_mux),
        .jump_target_id_i(jid), .jump_target_ex_i(jex), .pc_id_i(pcid), .hwlp_target_i(hwlp),
        .fetch_ready_i(fetch_ready),
        .branch_valid_o(valid3), .branch_addr_o(addr3),
        .csr_tvec_init_o(tvec3), .redirect_drop_o(drop3)
    );

    typedef struct {
        logic [3:0]  mux;
        logic [2:0]  exc;
        logic        ch;
        logic [1:0]  ch3;
        logic [31:0] exp;
        logic [31:0] exp3;
        logic        tvec;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{PC_EXC,    E_IRQ,  1'b1, 2'd1, 32'h00AB_CD1C, 32'h00AB_CD1C, 1'b0};
        vt[1]  = '{PC_EXC,    E_EXC,  1'b0, 2'd3, 32'h1234_5600, 32'h1234_5600, 1'b0};
        vt[2]  = '{PC_EXC,    E_IRQ,  1'b0, 2'd2, 32'h1234_560C, 32'h7777_7724, 1'b0};
        vt[3]  = '{PC_EXC,    E_DBD,  1'b1, 2'd1, 32'h1A00_0800, 32'h1A00_0800, 1'b0};
        vt[4]  = '{PC_EXC,    E_DBE,  1'b0, 2'd0, 32'h1A00_0C04, 32'h1A00_0C04, 1'b0};
        vt[5]  = '{PC_EXC,    3'd7,   1'b1, 2'd1, 32'h00AB_CD00, 32'h00AB_CD00, 1'b0};
        vt[6]  = '{PC_JUMP,   E_EXC,  1'b0, 2'd0, 32'h0000_0200, 32'h0000_0200, 1'b0};
        vt[7]  = '{PC_BRANCH, E_EXC,  1'b0, 2'd0, 32'h0000_0300, 32'h0000_0300, 1'b0};
        vt[8]  = '{PC_MRET,   E_EXC,  1'b1, 2'd2, 32'h1000_0000, 32'h1000_0000, 1'b0};
        vt[9]  = '{PC_URET,   E_EXC,  1'b0, 2'd0, 32'h2000_0000, 32'h3000_0000, 1'b0};
        vt[10] = '{PC_DRET,   E_EXC,  1'b0, 2'd0, 32'h0000_5554, 32'h0000_5554, 1'b0};
        vt[11] = '{PC_FENCEI, E_EXC,  1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[12] = '{PC_HWLP,   E_EXC,  1'b0, 2'd0, 32'h0000_0A0A, 32'h0000_0A0A, 1'b0};
        vt[13] = '{PC_BOOT,   E_EXC,  1'b0, 2'd0, 32'h0000_1080, 32'h0000_1080, 1'b1};

        rst = 1'b1;
        boot_addr = 32'h0000_1083; dm_halt = 32'h1A00_0803; dm_exc = 32'h1A00_0C07;
        depc = 32'h0000_5554; jid = 32'h0000_0200; jex = 32'h0000_0300;
        pcid = 32'hFFFF_FFFC; hwlp = 32'h0000_0A0A;
        trap_ch = 1'b0; trap_ch3 = 2'd0; exc_mux = E_EXC;
        pc_set = 1'b0; pc_mux = PC_JUMP; fetch_ready = 1'b0;

        // Boot offer held under reset and while not accepted; pc_set ignored in BOOT
        cyc(); cyc();
        chk("rst_valid", {31'b0, valid}, 32'd1);
        chk("rst_addr", addr, 32'h0000_1080);
        chk("rst_tvec", {31'b0, tvec}, 32'd0);
        chk("rst_drop", {31'b0, drop}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_set = 1'b1;
            cyc();
            chk("boot_hold_valid", {31'b0, valid}, 32'd1);
            chk("boot_hold_addr", addr, 32'h0000_1080);
            chk("boot_hold_tvec", {31'b0, tvec}, 32'd0);
        end
        pc_set = 1'b0; fetch_ready = 1'b1;
        cyc();
        fetch_ready = 1'b0;
        chk("boot_acc_valid", {31'b0, valid}, 32'd0);
        chk("boot_acc_tvec", {31'b0, tvec}, 32'd1);
        cyc();
        chk("boot_tvec_once", {31'b0, tvec}, 32'd0);
        chk("idle_valid", {31'b0, valid}, 32'd0);

        // One redirect per vector from IDLE, then accept
        for (int i = 0; i < 14; i++) begin
            pc_set = 1'b1; pc_mux = vt[i].mux; exc_mux = vt[i].exc;
            trap_ch = vt[i].ch; trap_ch3 = vt[i].ch3;
            cyc();
            pc_set = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'b0, valid}, 32'd1);
            chk($sformatf("v%0d_addr", i), addr, vt[i].exp);
            chk($sformatf("v%0d_addr3", i), addr3, vt[i].exp3);
            chk($sformatf("v%0d_tvec", i), {31'b0, tvec}, {31'b0, vt[i].tvec});
            chk($sformatf("v%0d_drop", i), {31'b0, drop}, 32'd0);
            fetch_ready = 1'b1;
            cyc();
            fetch_ready = 1'b0;
            chk($sformatf("v%0d_acc_valid", i), {31'b0, valid}, 32'd0);
            chk($sformatf("v%0d_acc_tvec", i), {31'b0, tvec}, 32'd0);
        end

        // Undefined encoding in IDLE is ignored
        pc_set = 1'b1; pc_mux = 4'hF;
        cyc();
        pc_set = 1'b0;
        chk("undef_idle_valid", {31'b0, valid}, 32'd0);

        // Overwrite while stalled: newest wins, one drop pulse
        pc_set = 1'b1; pc_mux = PC_JUMP;
        cyc();
        chk("ovr_first_addr", addr, 32'h0000_0200);
        chk("ovr_first_drop", {31'b0, drop}, 32'd0);
        pc_mux = PC_BRANCH;
        cyc();
        chk("ovr_second_addr", addr, 32'h0000_0300);
        chk("ovr_drop_pulse", {31'b0, drop}, 32'd1);
        pc_mux = 4'hB;
        cyc();
        pc_set = 1'b0;
        chk("ovr_undef_addr", addr, 32'h0000_0300);
        chk("ovr_drop_once", {31'b0, drop}, 32'd0);
        chk("ovr_valid", {31'b0, valid}, 32'd1);
        fetch_ready = 1'b1;
        cyc();
        fetch_ready = 1'b0;
        chk("ovr_acc_valid", {31'b0, valid}, 32'd0);

        // Accept and new set in the same cycle: back-to-back, no drop
        pc_set = 1'b1; pc_mux = PC_JUMP;
        cyc();
        pc_mux = PC_BRANCH; fetch_ready = 1'b1;
        cyc();
        pc_set = 1'b0;
        chk("b2b_valid", {31'b0, valid}, 32'd1);
        chk("b2b_addr", addr, 32'h0000_0300);
        chk("b2b_drop", {31'b0, drop}, 32'd0);
        cyc();
        fetch_ready = 1'b0;
        chk("b2b_acc_valid", {31'b0, valid}, 32'd0);

        // Reset while pending discards the entry
        jid = 32'h0000_0400; pc_set = 1'b1; pc_mux = PC_JUMP;
        cyc();
        pc_set = 1'b0;
        chk("rstp_pend_addr", addr, 32'h0000_0400);
        rst = 1'b1;
        #1;
        chk("rstp_async_valid", {31'b0, valid}, 32'd1);
        chk("rstp_async_addr", addr, 32'h0000_1080);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rstp_boot_valid", {31'b0, valid}, 32'd1);
        chk("rstp_boot_addr", addr, 32'h0000_1080);
        fetch_ready = 1'b1;
        cyc();
        fetch_ready = 1'b0;
        chk("rstp_acc_valid", {31'b0, valid}, 32'd0);
        chk("rstp_acc_tvec", {31'b0, tvec}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
